// File: rtl/tracking_iq_buffer.sv
// Purpose: circular show-ahead buffer for I/Q accumulation words, with sticky overflow/underflow flags.
// Latency: q shows the oldest entry combinationally. A word written into an empty buffer appears on q the next cycle.
// Backpressure: full/almost_full/empty come from registered state only. A write while full is dropped unless a read happens in the same cycle.
module tracking_iq_buffer #(
    parameter int WIDTH       = 108,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wrreq,
    input  logic [WIDTH-1:0]         data,
    input  logic                     rdreq,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         q,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   usedw,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic wr_acc;
    logic rd_acc;
    logic ovf_set;
    logic unf_set;

    // Accept decisions. A read in the same cycle frees a slot, so a write to a full buffer is still accepted then.
    always_comb begin
        rd_acc  = rdreq && !empty;
        wr_acc  = wrreq && (!full || rdreq);
        ovf_set = wrreq && full && !rdreq;
        unf_set = rdreq && empty;
    end

    // Status outputs come only from the count register.
    always_comb begin
        empty       = (count == '0);
        full        = (count == FULL_CNT);
        almost_full = (count >= AFULL_CNT);
        usedw       = count;
        q           = mem[rd_ptr];
    end

    // Storage write. It is blocked by reset and flush so that no request from that cycle completes.
    always_ff @(posedge clock) begin
        if (!reset && !flush && wr_acc) begin
            mem[wr_ptr] <= data;
        end
    end

    // Pointers and count. Reset and flush both clear them. They wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_acc && !rd_acc) begin
                count <= count + (AW+1)'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    // Sticky error flags. clr_err wins over a same-cycle set. A flush cycle never sets them.
    always_ff @(posedge clock) begin
        if (reset || clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tracking_iq_buffer.sv
// Purpose: directed self-checking bench for tracking_iq_buffer (DEPTH=4 main instance, DEPTH=8 wrap instance).
// Latency: inputs are driven #1 after a rising edge, and outputs are sampled #1 after the following edge.
// Backpressure: the wrap test paces writes and reads so that occupancy stays between 3 and 6.
module tb_tracking_iq_buffer;

    localparam int W = 108;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // DEPTH=4 instance
    logic         reset, flush, wrreq, rdreq, clr_err;
    logic [W-1:0] data, q;
    logic         empty, full, almost_full, overflow, underflow;
    logic [2:0]   usedw;

    // DEPTH=8 instance
    logic         w_reset, w_flush, w_wrreq, w_rdreq, w_clr_err;
    logic [W-1:0] w_data, w_q;
    logic         w_empty, w_full, w_almost_full, w_overflow, w_underflow;
    logic [3:0]   w_usedw;

    int checks = 0;
    int passed = 0;

    tracking_iq_buffer #(.WIDTH(W), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .flush(flush), .wrreq(wrreq), .data(data),
        .rdreq(rdreq), .clr_err(clr_err), .q(q), .empty(empty), .full(full),
        .almost_full(almost_full), .usedw(usedw), .overflow(overflow), .underflow(underflow)
    );

    tracking_iq_buffer #(.WIDTH(W), .DEPTH(8)) dut8 (
        .clock(clock), .reset(w_reset), .flush(w_flush), .wrreq(w_wrreq), .data(w_data),
        .rdreq(w_rdreq), .clr_err(w_clr_err), .q(w_q), .empty(w_empty), .full(w_full),
        .almost_full(w_almost_full), .usedw(w_usedw), .overflow(w_overflow), .underflow(w_underflow)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        wrreq = 0; rdreq = 0; flush = 0; clr_err = 0; reset = 0;
    endtask

    task automatic push(input logic [W-1:0] v);
        wrreq = 1; data = v;
        tick();
        wrreq = 0;
    endtask

    task automatic pop_expect(input string tag, input logic [W-1:0] v);
        check(tag, q, v);
        rdreq = 1;
        tick();
        rdreq = 0;
    endtask

    initial begin
        logic [W-1:0] expq[$];
        int cnt, widx, nread;
        idle();
        data = '0;
        w_reset = 1; w_flush = 0; w_wrreq = 0; w_rdreq = 0; w_clr_err = 0; w_data = '0;
        reset = 1;
        #2;
        tick();
        reset = 0; w_reset = 0;

        // Reset state
        check("rst_usedw", usedw, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);

        // Fill with 1..4, then drain
        for (int i = 1; i <= 4; i++) begin
            push(W'(i));
            check("fill_usedw", usedw, i);
            check("fill_afull", almost_full, (i >= 3) ? 1 : 0);
            check("fill_full", full, (i == 4) ? 1 : 0);
            check("fill_q", q, 1);
            check("fill_empty", empty, 0);
        end
        for (int i = 1; i <= 4; i++) pop_expect("drain_q", W'(i));
        check("drain_empty", empty, 1);
        check("drain_unf", underflow, 0);

        // Overflow: a write while full is dropped
        for (int i = 1; i <= 4; i++) push(W'(i));
        push(W'(5));
        check("ovf_usedw", usedw, 4);
        check("ovf_flag", overflow, 1);
        for (int i = 1; i <= 4; i++) pop_expect("ovf_q", W'(i));
        check("ovf_empty", empty, 1);
        clr_err = 1; tick(); clr_err = 0;
        check("ovf_clr", overflow, 0);

        // Full with a simultaneous read and write
        for (int i = 1; i <= 4; i++) push(W'(i));
        wrreq = 1; rdreq = 1; data = W'(5);
        tick();
        idle();
        check("frw_usedw", usedw, 4);
        check("frw_ovf", overflow, 0);
        for (int i = 2; i <= 5; i++) pop_expect("frw_q", W'(i));
        check("frw_empty", empty, 1);

        // Empty with a simultaneous read and write
        wrreq = 1; rdreq = 1; data = W'(10);
        tick();
        idle();
        check("erw_unf", underflow, 1);
        check("erw_usedw", usedw, 1);
        check("erw_q", q, 10);
        pop_expect("erw_pop", W'(10));
        check("erw_empty", empty, 1);

        // clr_err takes priority over a same-cycle underflow
        rdreq = 1; clr_err = 1;
        tick();
        idle();
        check("clr_prio_unf", underflow, 0);

        // Flush keeps the sticky flags and ignores a same-cycle write
        for (int i = 1; i <= 4; i++) push(W'(i));
        push(W'(7));
        pop_expect("fl_pre_q", W'(1));
        check("fl_pre_usedw", usedw, 3);
        flush = 1; wrreq = 1; data = W'(9);
        tick();
        idle();
        check("fl_usedw", usedw, 0);
        check("fl_empty", empty, 1);
        check("fl_ovf", overflow, 1);
        check("fl_unf", underflow, 0);

        // Flush on an empty buffer with a read does not set underflow
        flush = 1; rdreq = 1;
        tick();
        idle();
        check("fl_rd_unf", underflow, 0);

        // Reset clears overflow and discards a same-cycle write
        reset = 1; wrreq = 1; data = W'(3);
        tick();
        idle();
        check("rst2_ovf", overflow, 0);
        check("rst2_usedw", usedw, 0);
        check("rst2_empty", empty, 1);

        // Wrap test on DEPTH=8: 20 words, occupancy 3..6 while writing
        cnt = 0; widx = 0; nread = 0;
        for (int cyc = 0; cyc < 300 && nread < 20; cyc++) begin
            logic wr, rd;
            wr = (widx < 20) && (cnt < 6) && (cyc % 3 != 2);
            rd = (widx < 20) ? (cnt > 3 && cyc % 2 == 1) : (cnt > 0);
            w_wrreq = wr; w_rdreq = rd; w_data = W'(32'hA000 + widx);
            if (rd) begin
                check("wrap_q", w_q, expq.pop_front());
                nread++;
            end
            if (wr) begin
                expq.push_back(W'(32'hA000 + widx));
                widx++;
            end
            cnt = cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
            tick();
            w_wrreq = 0; w_rdreq = 0;
            check("wrap_usedw", w_usedw, cnt);
        end
        check("wrap_nread", nread, 20);
        check("wrap_empty", w_empty, 1);
        check("wrap_ovf", w_overflow, 0);
        check("wrap_unf", w_underflow, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tracking_iq_buffer.md
TRACKING_IQ_BUFFER -- requirements
Module: tracking_iq_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 108: entry width in bits (I/Q accumulation word).
REQ-002 SHALL have parameter DEPTH, default 4: entries stored; power of two, 2..256.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-1: count at or above which almost_full asserts; 1..DEPTH.
REQ-004 SHALL derive AW = log2(DEPTH) internally; AW is not a port-visible parameter.
REQ-005 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port flush  in  1  synchronous clear of contents only; error flags retained.
REQ-008 SHALL have port wrreq  in  1  write strobe.
REQ-009 SHALL have port data  in  WIDTH  write data.
REQ-010 SHALL have port rdreq  in  1  read/pop strobe.
REQ-011 SHALL have port q  out  WIDTH  oldest entry (show-ahead).
REQ-012 SHALL have port empty  out  1  count == 0.
REQ-013 SHALL have port full  out  1  count == DEPTH.
REQ-014 SHALL have port almost_full  out  1  count >= AFULL_LEVEL.
REQ-015 SHALL have port usedw  out  AW+1  current entry count, 0..DEPTH.
REQ-016 SHALL have port overflow  out  1  sticky: write attempted while full.
REQ-017 SHALL have port underflow  out  1  sticky: read attempted while empty.
REQ-018 SHALL have port clr_err  in  1  synchronous clear of overflow/underflow.

Function
REQ-019 SHALL be circular storage with AW-bit write/read pointers wrapping DEPTH-1 -> 0, plus AW+1-bit count register.
REQ-020 SHALL present q = entry at read pointer combinationally whenever empty=0 (zero-latency show-ahead); q is don't-care but stable (last storage value) when empty=1.
REQ-021 SHALL derive empty, full, almost_full, usedw from count register only, all registered-state outputs (no combinational path from wrreq/rdreq).
REQ-022 SHALL accept a write when wrreq=1 and (full=0 or rdreq=1): store data at write pointer, advance write pointer.
REQ-023 SHALL accept a read when rdreq=1 and empty=0: advance read pointer.
REQ-024 SHALL, on wrreq=1 while full=1 and rdreq=0, discard data, leave state unchanged, set overflow next cycle.
REQ-025 SHALL, on rdreq=1 while empty=1, ignore the read (any simultaneous write is still accepted, count becomes 1), set underflow next cycle.
REQ-026 SHALL, on simultaneous accepted read and write, hold count; when full, the written word occupies the slot freed by the read.
REQ-027 SHALL update count: +1 write only, -1 read only, unchanged both/neither; never outside 0..DEPTH.
REQ-028 SHALL, on flush=1, next cycle set pointers and count to 0 regardless of wrreq/rdreq that cycle; overflow/underflow not set by that cycle's requests.
REQ-029 SHALL give clr_err priority over a same-cycle set: flags read 0 next cycle.
REQ-030 SHALL give q of a newly written word to an empty buffer on the cycle after the write (empty deasserts the same cycle).

Reset
REQ-031 SHALL, on reset=1, next cycle: pointers=0, usedw=0, empty=1, full=0, almost_full=0 (unless AFULL_LEVEL... minimum 1 ensures 0), overflow=0, underflow=0; reset dominates flush, clr_err, wrreq, rdreq.
REQ-032 SHALL not require storage contents to be cleared by reset or flush.
REQ-033 SHALL, on reset asserted mid-operation, discard all contents and complete no request made in that cycle.

Verification
REQ-034 Defaults: reset; write 0x1,0x2,0x3,0x4 -> usedw 1..4, almost_full at usedw=3, full at 4, q=0x1 throughout; four reads -> q 0x2,0x3,0x4, then empty=1.
REQ-035 Overflow: full with 0x1..0x4, write 0x5 alone -> usedw stays 4, overflow=1, q sequence 0x1..0x4; clr_err -> overflow=0.
REQ-036 Full read+write: full with 0x1..0x4, wrreq+rdreq with 0x5 -> usedw 4, overflow=0, drain yields 0x2,0x3,0x4,0x5.
REQ-037 Empty read+write: empty, rdreq+wrreq with 0xA -> underflow=1, usedw=1, q=0xA.
REQ-038 Wrap: DEPTH=8, 20 writes interleaved with reads keeping usedw 3..6 -> output order identical to input order, pointers wrap without loss.
REQ-039 Flush/reset: usedw=3, assert flush with wrreq -> usedw=0, empty=1, sticky flags unchanged; assert reset with clr_err=0 and overflow=1 -> overflow=0.
